lif_dualleak_neuron: RTL and testbench

LIF_DUALLEAK_NEURON -- requirements
Module: lif_dualleak_neuron

---
 rtl/lif_pkg.sv | 26 ++
 rtl/lif_leak_timer.sv | 34 +++
 rtl/lif_dualleak_neuron.sv | 170 +++++++++++++++++
 tb/tb_lif_dualleak_neuron.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the dual-leak LIF neuron.
// Holds state encoding, datapath widths and the saturating update helper.
package lif_pkg;

  localparam int V_W  = 8;
  localparam int LT_W = 4;

  localparam logic [LT_W-1:0] DEF_REFRACTORY_CYCLES = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_INTEGRATE  = 2'd1,
    ST_REFRACTORY = 2'd2
  } lif_state_t;

  // Floor at zero, then clamp to the top of the potential range.
  function automatic logic [V_W-1:0] sat_sub(
    input logic [V_W:0] s,
    input logic [V_W:0] l
  );
    logic [V_W:0] d;
    d = (s > l) ? (s - l) : '0;
    return d[V_W] ? {V_W{1'b1}} : d[V_W-1:0];
  endfunction

endpackage

// File: rtl/lif_leak_timer.sv
// Periodic leak event generator for one leak channel.
// Ports: clk, reset (sync, high), run, clear, period[3:0] -> tick.
module lif_leak_timer
  import lif_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            clear,
  input  logic [LT_W-1:0] period,
  output logic            tick
);

  logic [LT_W-1:0] r_cnt;
  logic            w_on;

  assign w_on = (period != '0);

  // A period of 0 disables the channel entirely.
  assign tick = run && w_on &&
                (r_cnt >= (period - 4'd1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (run) begin
      if (!w_on || tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/lif_dualleak_neuron.sv
// Leaky integrate-and-fire neuron with two independent leak channels.
// Ports: clk, reset, enable, params_ready, spike_in, weight_a,
//   leak_rate_1/2, threshold, leak_cycles_1/2 -> spike_out,
//   membrane_potential, state_out, spike_count.
module lif_dualleak_neuron
  import lif_pkg::*;
#(
  parameter logic [LT_W-1:0] REFRACTORY_CYCLES = DEF_REFRACTORY_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            params_ready,
  input  logic            spike_in,
  input  logic [2:0]      weight_a,
  input  logic [V_W-1:0]  leak_rate_1,
  input  logic [V_W-1:0]  leak_rate_2,
  input  logic [V_W-1:0]  threshold,
  input  logic [LT_W-1:0] leak_cycles_1,
  input  logic [LT_W-1:0] leak_cycles_2,
  output logic            spike_out,
  output logic [V_W-1:0]  membrane_potential,
  output logic [1:0]      state_out,
  output logic [7:0]      spike_count
);

  lif_state_t      r_state;
  lif_state_t      w_state_nxt;
  logic [V_W-1:0]  r_v;
  logic [V_W-1:0]  w_v_nxt;
  logic            r_spike;
  logic            w_spike_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [LT_W-1:0] r_ref;
  logic [LT_W-1:0] w_ref_nxt;

  logic            w_run;
  logic            w_clr;
  logic            w_tick1;
  logic            w_tick2;
  logic [V_W:0]    w_sum;
  logic [V_W:0]    w_leak;
  logic [V_W-1:0]  w_r;
  logic            w_fire;

  lif_leak_timer u_leak1 (
    .clk    (clk),
    .reset  (reset),
    .run    (w_run),
    .clear  (w_clr),
    .period (leak_cycles_1),
    .tick   (w_tick1)
  );

  lif_leak_timer u_leak2 (
    .clk    (clk),
    .reset  (reset),
    .run    (w_run),
    .clear  (w_clr),
    .period (leak_cycles_2),
    .tick   (w_tick2)
  );

  // Integration datapath, 9 bits wide so the sum never wraps.
  always_comb begin
    w_sum  = {1'b0, r_v} +
             (spike_in ? {6'd0, weight_a} : 9'd0);
    w_leak = (w_tick1 ? {1'b0, leak_rate_1} : 9'd0) +
             (w_tick2 ? {1'b0, leak_rate_2} : 9'd0);
    w_r    = sat_sub(w_sum, w_leak);
    w_fire = (r_state == ST_INTEGRATE) &&
             (w_r >= threshold);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else if (enable)
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (params_ready) begin
      case (r_state)
        ST_IDLE:
          w_state_nxt = ST_INTEGRATE;
        ST_INTEGRATE:
          w_state_nxt = (w_fire && REFRACTORY_CYCLES != '0)
                      ? ST_REFRACTORY : ST_INTEGRATE;
        ST_REFRACTORY:
          w_state_nxt = (r_ref <= 4'd1)
                      ? ST_INTEGRATE : ST_REFRACTORY;
        default:
          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output / datapath update logic
  always_comb begin
    w_v_nxt     = r_v;
    w_spike_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_ref_nxt   = r_ref;
    w_run       = 1'b0;
    w_clr       = 1'b0;
    if (!params_ready) begin
      w_v_nxt   = '0;
      w_ref_nxt = '0;
      w_clr     = enable;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_v_nxt   = '0;
          w_ref_nxt = '0;
          w_clr     = enable;
        end
        ST_INTEGRATE: begin
          w_run = enable;
          if (w_fire) begin
            w_v_nxt     = '0;
            w_spike_nxt = 1'b1;
            w_cnt_nxt   = r_cnt + 8'd1;
            w_ref_nxt   = REFRACTORY_CYCLES;
            w_clr       = enable;
          end else begin
            w_v_nxt = w_r;
          end
        end
        ST_REFRACTORY: begin
          w_v_nxt   = '0;
          w_clr     = enable;
          w_ref_nxt = (r_ref != '0) ? r_ref - 4'd1 : '0;
        end
        default: begin
          w_v_nxt   = '0;
          w_ref_nxt = '0;
          w_clr     = enable;
        end
      endcase
    end
  end

  // Datapath registers; a disabled cycle holds all but the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v     <= '0;
      r_spike <= 1'b0;
      r_cnt   <= '0;
      r_ref   <= '0;
    end else if (enable) begin
      r_v     <= w_v_nxt;
      r_spike <= w_spike_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ref   <= w_ref_nxt;
    end else begin
      r_spike <= 1'b0;
    end
  end

  assign spike_out          = r_spike;
  assign membrane_potential = r_v;
  assign state_out          = r_state;
  assign spike_count        = r_cnt;

endmodule

// File: tb/tb_lif_dualleak_neuron.sv
// Directed self-checking bench for lif_dualleak_neuron.
// Runs a default instance and a zero-refractory instance side by side.
module tb_lif_dualleak_neuron;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       prdy;
  logic       sin;
  logic [2:0] wa;
  logic [7:0] lr1;
  logic [7:0] lr2;
  logic [7:0] thr;
  logic [3:0] lc1;
  logic [3:0] lc2;

  logic       so;
  logic [7:0] vm;
  logic [1:0] st;
  logic [7:0] sc;
  logic       so0;
  logic [7:0] vm0;
  logic [1:0] st0;
  logic [7:0] sc0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lif_dualleak_neuron dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (en),
    .params_ready       (prdy),
    .spike_in           (sin),
    .weight_a           (wa),
    .leak_rate_1        (lr1),
    .leak_rate_2        (lr2),
    .threshold          (thr),
    .leak_cycles_1      (lc1),
    .leak_cycles_2      (lc2),
    .spike_out          (so),
    .membrane_potential (vm),
    .state_out          (st),
    .spike_count        (sc)
  );

  lif_dualleak_neuron #(.REFRACTORY_CYCLES(4'd0)) dut0 (
    .clk                (clk),
    .reset              (reset),
    .enable             (en),
    .params_ready       (prdy),
    .spike_in           (sin),
    .weight_a           (wa),
    .leak_rate_1        (lr1),
    .leak_rate_2        (lr2),
    .threshold          (thr),
    .leak_cycles_1      (lc1),
    .leak_cycles_2      (lc2),
    .spike_out          (so0),
    .membrane_potential (vm0),
    .state_out          (st0),
    .spike_count        (sc0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; prdy = 1'b1; sin = 1'b0;
    wa = 3'd0; lr1 = 8'd0; lr2 = 8'd0; thr = 8'd30;
    lc1 = 4'd0; lc2 = 4'd0;
    step(); step();
    chk("rst_state", int'(st), 0);
    chk("rst_v", int'(vm), 0);
    chk("rst_spike", int'(so), 0);
    chk("rst_count", int'(sc), 0);

    // Constant-weight climb to threshold 30 and refractory.
    wa = 3'd2; sin = 1'b1; reset = 1'b0;
    step();
    chk("idle_to_int", int'(st), 1);
    chk("idle_no_integ", int'(vm), 0);
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("climb_v", int'(vm), 2 * i);
      chk("climb_nospk", int'(so), 0);
    end
    step();
    chk("fire_spike", int'(so), 1);
    chk("fire_v", int'(vm), 0);
    chk("fire_count", int'(sc), 1);
    chk("fire_state", int'(st), 2);
    step();
    chk("ref1_state", int'(st), 2);
    chk("ref1_spike", int'(so), 0);
    chk("ref1_v", int'(vm), 0);
    step();
    chk("ref_exit", int'(st), 1);
    chk("ref_exit_v", int'(vm), 0);
    step();
    chk("post_ref_v", int'(vm), 2);

    // Primary leak floors the potential at zero.
    prdy = 1'b0;
    step();
    chk("prdy_idle", int'(st), 0);
    chk("prdy_v", int'(vm), 0);
    prdy = 1'b1; wa = 3'd4; thr = 8'd200;
    step();
    chk("l1_int", int'(st), 1);
    step(); step(); step();
    chk("l1_v12", int'(vm), 12);
    sin = 1'b0; lr1 = 8'd5; lc1 = 4'd1;
    step(); chk("l1_v7", int'(vm), 7);
    step(); chk("l1_v2", int'(vm), 2);
    step(); chk("l1_v0a", int'(vm), 0);
    step(); chk("l1_v0b", int'(vm), 0);
    chk("l1_nofire", int'(sc), 1);

    // Two leak channels coinciding on the fourth cycle.
    prdy = 1'b0;
    step();
    wa = 3'd2; lr1 = 8'd2; lc1 = 4'd2;
    lr2 = 8'd1; lc2 = 4'd4; thr = 8'd30;
    sin = 1'b1; prdy = 1'b1;
    step();
    chk("dl_int", int'(st), 1);
    step(); chk("dl_c1", int'(vm), 2);
    step(); chk("dl_c2", int'(vm), 2);
    step(); chk("dl_c3", int'(vm), 4);
    step(); chk("dl_c4", int'(vm), 3);

    // Freeze mid-integration.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_v", int'(vm), 3);
      chk("frz_state", int'(st), 1);
      chk("frz_spike", int'(so), 0);
    end
    en = 1'b1;
    step(); chk("frz_c5", int'(vm), 5);
    step(); chk("frz_c6", int'(vm), 5);
    step(); chk("frz_c7", int'(vm), 7);
    step(); chk("frz_c8", int'(vm), 6);

    // Saturation at 255 with threshold 255.
    prdy = 1'b0;
    step();
    wa = 3'd7; thr = 8'd255; lc1 = 4'd0; lc2 = 4'd0;
    prdy = 1'b1;
    step();
    for (int i = 1; i <= 36; i++) begin
      step();
      chk("sat_climb", int'(vm), 7 * i);
    end
    chk("sat_252", int'(vm), 252);
    step();
    chk("sat_fire", int'(so), 1);
    chk("sat_v0", int'(vm), 0);
    chk("sat_count", int'(sc), 2);
    chk("sat_ref", int'(st), 2);

    // params_ready drop during refractory.
    prdy = 1'b0;
    step();
    chk("ref_abort_st", int'(st), 0);
    chk("ref_abort_v", int'(vm), 0);

    // Reset mid-integration aborts.
    prdy = 1'b1;
    step(); step(); step();
    chk("mid_v", int'(vm), 14);
    reset = 1'b1;
    step();
    chk("mid_rst_st", int'(st), 0);
    chk("mid_rst_v", int'(vm), 0);
    chk("mid_rst_cnt", int'(sc), 0);

    // Zero threshold, zero refractory: fire every cycle, count wraps.
    sin = 1'b0; wa = 3'd0; thr = 8'd0;
    reset = 1'b0;
    step();
    chk("z_int", int'(st0), 1);
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("z_spike", int'(so0), 1);
      chk("z_state", int'(st0), 1);
      if (i == 255)
        chk("z_cnt255", int'(sc0), 255);
    end
    chk("z_wrap", int'(sc0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
